// File: rtl/prog_clk_divider_if.sv
// prog_clk_divider_if: control and status bundle for prog_clk_divider
interface prog_clk_divider_if #(parameter int N_CH = 4, CNT_W = 32, CH_W = 2);
  logic [N_CH-1:0]  en;
  logic             sync;
  logic             load;
  logic [CH_W-1:0]  load_ch;
  logic [CNT_W-1:0] load_div;
  logic [N_CH-1:0]  div_out;
  logic [N_CH-1:0]  tick;
  logic             cfg_err;
  modport master(output en, sync, load, load_ch, load_div, input div_out, tick, cfg_err);
  modport slave(input en, sync, load, load_ch, load_div, output div_out, tick, cfg_err);
endinterface

// File: rtl/prog_clk_divider.sv
// prog_clk_divider: N_CH-channel runtime-programmable divider with tick and square outputs.
// Define DIV_SHADOW_EN to defer accepted loads on running channels to their next terminal count.
module prog_clk_divider #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 32,
  parameter int DEF_DIV = 16,
  parameter int CH_W    = 2
) (
  input logic               clk_50MHz,
  input logic               rst,
  prog_clk_divider_if.slave bus
);
  logic ok, cfg_err_q;
  assign ok = bus.load && ({1'b0, bus.load_ch} < (CH_W+1)'(N_CH)) && (bus.load_div >= CNT_W'(2));
  always_ff @(posedge clk_50MHz) cfg_err_q <= rst && bus.load && !ok;
  assign bus.cfg_err = cfg_err_q;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n, div_q, div_d;
    logic tick_q, dout_q, dout_d, sel, hit, wrap, restart;
    assign sel = ok && (bus.load_ch == CH_W'(c));
    assign hit = cnt_q == div_q - CNT_W'(1);
`ifdef DIV_SHADOW_EN
    logic [CNT_W-1:0] shd_q, shd_d;
    logic pend_q, pend_d, now, defer;
    // A running channel keeps its phase; the new ratio lands on the wrap edge.
    always_comb begin
      now     = sel && (!bus.en[c] || bus.sync);
      defer   = sel && !now;
      restart = bus.sync || now;
    end
    always_comb begin
      div_d  = now ? bus.load_div : (wrap && pend_q) ? shd_q : div_q;
      shd_d  = defer ? bus.load_div : shd_q;
      pend_d = defer || (pend_q && !wrap && !now);
    end
    always_ff @(posedge clk_50MHz)
      if (!rst) begin
        shd_q  <= CNT_W'(DEF_DIV);
        pend_q <= 1'b0;
      end else begin
        shd_q  <= shd_d;
        pend_q <= pend_d;
      end
`else
    always_comb begin
      restart = bus.sync || sel;
      div_d   = sel ? bus.load_div : div_q;
    end
`endif
    always_comb begin
      wrap   = bus.en[c] && hit && !restart;
      cnt_n  = wrap ? '0 : cnt_q + CNT_W'(1);
      cnt_d  = restart ? '0 : bus.en[c] ? cnt_n : cnt_q;
      dout_d = restart ? 1'b0 : bus.en[c] ? (cnt_n >= div_q - (div_q >> 1)) : dout_q;
    end
    always_ff @(posedge clk_50MHz)
      if (!rst) begin
        cnt_q  <= '0;
        div_q  <= CNT_W'(DEF_DIV);
        tick_q <= 1'b0;
        dout_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        tick_q <= wrap;
        dout_q <= dout_d;
      end
    assign bus.tick[c]    = tick_q;
    assign bus.div_out[c] = dout_q;
  end
endmodule

// File: tb/tb_prog_clk_divider.sv
// tb_prog_clk_divider: randomized scoreboard bench for prog_clk_divider with an edge-count reference model
module tb_prog_clk_divider;
  localparam int N = 3, W = 32, D = 16, CW = 2;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  prog_clk_divider_if #(.N_CH(N), .CNT_W(W), .CH_W(CW)) bus();
  prog_clk_divider #(.N_CH(N), .CNT_W(W), .DEF_DIV(D), .CH_W(CW)) dut (
    .clk_50MHz(clk),
    .rst(rst),
    .bus(bus)
  );
  typedef struct packed {logic [N-1:0] tick; logic [N-1:0] out; logic err;} exp_t;
  exp_t q[$];
  exp_t x;
  int checks = 0, failures = 0;
  // Model: enabled edges since restart; phase is that count modulo the ratio.
  longint k[N], dv[N];

  function automatic void cmp(input string n, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", n, $time, act, req);
    end
  endfunction

  task automatic step(input logic r, input logic [N-1:0] e, input logic s, input logic l,
                      input logic [CW-1:0] ch, input logic [W-1:0] ld);
    exp_t m;
    bit acc;
    @(negedge clk);
    rst = r; bus.en = e; bus.sync = s; bus.load = l; bus.load_ch = ch; bus.load_div = ld;
    acc = l && (int'(ch) < N) && (ld >= 2);
    m.err = r && l && !acc;
    for (int c = 0; c < N; c++) begin
      if (!r) begin
        dv[c] = D; k[c] = 0; m.tick[c] = 1'b0;
      end else if (s || (acc && int'(ch) == c)) begin
        if (acc && int'(ch) == c) dv[c] = longint'(ld);
        k[c] = 0; m.tick[c] = 1'b0;
      end else if (e[c]) begin
        k[c]++;
        m.tick[c] = (k[c] % dv[c]) == 0;
      end else m.tick[c] = 1'b0;
      m.out[c] = (k[c] % dv[c]) >= (dv[c] + 1) / 2;
    end
    q.push_back(m);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      cmp("tick", int'(bus.tick), int'(x.tick));
      cmp("div_out", int'(bus.div_out), int'(x.out));
      cmp("cfg_err", int'(bus.cfg_err), int'(x.err));
    end
  end

  initial begin
    bus.en = '0; bus.sync = 1'b0; bus.load = 1'b0; bus.load_ch = '0; bus.load_div = '0;
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    repeat (40) step(1'b1, '1, 1'b0, 1'b0, '0, '0);
    step(1'b1, '1, 1'b0, 1'b1, 2'd1, 32'd5);
    repeat (12) step(1'b1, '1, 1'b0, 1'b0, '0, '0);
    step(1'b1, '1, 1'b0, 1'b1, 2'd0, 32'd1);
    step(1'b1, '1, 1'b0, 1'b1, 2'd3, 32'd7);
    step(1'b1, '1, 1'b0, 1'b1, 2'd2, 32'd0);
    repeat (5) step(1'b1, '1, 1'b0, 1'b0, '0, '0);
    repeat (7) step(1'b1, 3'b110, 1'b0, 1'b0, '0, '0);
    repeat (20) step(1'b1, '1, 1'b0, 1'b0, '0, '0);
    step(1'b1, '1, 1'b1, 1'b1, 2'd2, 32'd4);
    repeat (20) step(1'b1, '1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 3'b011, 1'b0, 1'b1, 2'd2, 32'd3);
    repeat (4) step(1'b1, 3'b011, 1'b0, 1'b0, '0, '0);
    step(1'b1, '1, 1'b0, 1'b1, 2'd0, 32'd2);
    repeat (6) step(1'b1, '1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] e;
      for (int c = 0; c < N; c++) e[c] = $urandom_range(0, 9) != 0;
      step($urandom_range(0, 199) != 0, e, $urandom_range(0, 59) == 0, $urandom_range(0, 11) == 0,
           CW'($urandom_range(0, 3)),
           $urandom_range(0, 4) == 0 ? W'($urandom_range(0, 1)) :
           $urandom_range(0, 9) == 0 ? W'($urandom_range(13, 40)) : W'($urandom_range(2, 12)));
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
